multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL change on the rising clock edge only.
REQ-002 clk  in  1  clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 Op  in  2  instr[27:26], sampled from the instruction register.
REQ-005 Funct  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S or L.
REQ-006 Rd  in  4  instr[15:12].
REQ-007 Cond  in  4  instr[31:28].
REQ-008 ALUFlags  in  4  NZCV from the ALU, current cycle.
REQ-009 MemReady  in  1  memory completes the access this cycle.
REQ-010 PCWrite  out  1  PC register enable.
REQ-011 AdrSrc  out  1  memory address select; 0=PC, 1=ALUOut.
REQ-012 MemWrite  out  1  memory write enable.
REQ-013 IRWrite  out  1  instruction register enable.
REQ-014 ResultSrc  out  2  result mux; 00=ALUOut, 01=Data, 10=ALUResult.
REQ-015 ALUSrcA  out  1  0=RD1, 1=PC.
REQ-016 ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4.
REQ-017 ImmSrc  out  2  equals Op.
REQ-018 RegSrc  out  2  [1]=(Op==01), [0]=(Op==10).
REQ-019 RegWrite  out  1  register file write enable.
REQ-020 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-021 Flags  out  4  architectural NZCV register.
REQ-022 State  out  4  current FSM state, for debug.

Function
REQ-023 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge with all enables 0.
REQ-024 Transitions SHALL be:
- FETCH->DECODE when MemReady=1, else stay in FETCH.
- DECODE->MEMADR when Op=01; EXECUTEI when Op=00 and Funct[5]=1; EXECUTER when Op=00 and Funct[5]=0; BRANCH when Op=10; FETCH when Op=11.
- MEMADR->MEMREAD when Funct[0]=1, else MEMWRITE.
- MEMREAD->MEMWB when MemReady=1, else stay.
- MEMWRITE->FETCH when MemReady=1, else stay.
- EXECUTER and EXECUTEI->ALUWB.
- MEMWB, ALUWB and BRANCH->FETCH.
REQ-025 Outputs SHALL be Moore per state; any output not listed for a state SHALL be 0:
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=MemReady, NextPC=MemReady.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR and EXECUTEI: ALUSrcA=0, ALUSrcB=01.
- EXECUTER: ALUSrcA=0, ALUSrcB=00.
- MEMREAD: AdrSrc=1.
- MEMWRITE: AdrSrc=1, MemW=1 on every cycle in the state.
- MEMWB: ResultSrc=01, RegW=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-026 ALUOp SHALL be 1 only in EXECUTER and EXECUTEI; when ALUOp=0, ALUControl SHALL be 00.
REQ-027 When ALUOp=1, ALUControl SHALL decode Funct[4:1] as 0100->00, 0010->01, 0000->10, 1100->11, and any other value->10.
REQ-028 CondEx SHALL be combinational from Cond and the Flags register:
- EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE per the ARM definitions.
- 1110 (AL) SHALL give 1; 1111 SHALL give 0.
REQ-029 The gated enables SHALL be:
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd==1111))).
REQ-030 Flags update:
- Flags[3:2] SHALL load ALUFlags[3:2] when ALUOp & Funct[0] & CondEx.
- Flags[1:0] SHALL load ALUFlags[1:0] when that condition holds and ALUControl is 00 or 01.
- In all other cases Flags SHALL hold.
REQ-031 Instruction latency SHALL be, with MemReady=1 throughout:
- LDR: 5 cycles.
- STR: 4 cycles.
- Data processing: 4 cycles.
- B: 3 cycles.
- Op=11: 2 cycles.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE SHALL add 1 cycle.
REQ-032 A false condition SHALL suppress writes only; the state sequence and cycle count SHALL be unchanged.

Reset
REQ-033 While reset_n=0, State SHALL be FETCH and Flags SHALL be 0000, independent of clk.
REQ-034 An assertion of reset_n in any state SHALL abort the instruction; in the first cycle after release, only the FETCH outputs SHALL be driven, with no register or memory write caused by the aborted instruction.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, then MemReady=1, Op=00, Funct=101001 (ADDS #imm), Cond=1110, ALUFlags=0110 -> states 0,1,7,8,0; RegWrite=1 in ALUWB; Flags=0110 after EXECUTEI.
- LDR with Op=01, Funct[0]=1 and MemReady=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4; RegWrite asserted once.
- STR with Cond=0000 (EQ) and Flags Z=0 -> MEMWRITE reached with MemWrite=0 throughout.
- B with Cond=1110 -> PCWrite=1 in FETCH and in BRANCH; ALUSrcB=01 in BRANCH.
- ORR with S=1 (Funct=011001) and ALUFlags=1111 from Flags=0000 -> Flags=1100.
- reset_n pulsed low in MEMWRITE -> State=0 immediately and MemWrite=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore FSM, ALU decoder, condition check and NZCV flags.
// Write enables are gated by the condition; the state sequence does not depend on it.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;
  logic       next_pc, branch, reg_w, mem_w, alu_op, cond_ex;
  logic       n_f, z_f, c_f, v_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        next_state = MemReady ? DECODE : FETCH;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = MemReady;
        next_pc    = MemReady;
      end
      DECODE: begin
        case (Op)
          2'b00:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        next_state = Funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB    = 2'b01;
      end
      MEMREAD: begin
        next_state = MemReady ? MEMWB : MEMREAD;
        AdrSrc     = 1'b1;
      end
      MEMWRITE: begin
        next_state = MemReady ? FETCH : MEMWRITE;
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      EXECUTER: begin
        next_state = ALUWB;
        alu_op     = 1'b1;
      end
      EXECUTEI: begin
        next_state = ALUWB;
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b10;
      endcase
    end
  end

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~(c_f & ~z_f);
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Logic ops (AND/ORR) leave C and V untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= 4'b0000;
    end else if (alu_op & Funct[0] & cond_ex) begin
      flags[3:2] <= ALUFlags[3:2];
      if (!ALUControl[1]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign RegWrite = reg_w & cond_ex;
  assign MemWrite = mem_w & cond_ex;
  assign PCWrite  = next_pc | (cond_ex & (branch | (reg_w & (Rd == 4'b1111))));
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign Flags    = flags;
  assign State    = state;

endmodule
